gshare_spec_predictor: RTL and testbench

Parametrised next-generation gshare direction predictor with an integrated BTB, sitting in the IF stage of the pipelined core. It extends the earlier gshare block in four ways:
- speculative global history, updated at predict time;
- per-branch history snapshots carried down the pipeline, with history repair on mispredict;
- BTB valid bits;
- a sequenced table-init FSM in place of a bulk reset.

A mode parameter selects gshare or bimodal indexing.

---
 rtl/gshare_spec_predictor_pkg.sv | 25 ++
 rtl/gshare_spec_predictor_if.sv | 30 +++
 rtl/gshare_spec_predictor_btb_table.sv | 41 ++++
 rtl/gshare_spec_predictor.sv | 119 +++++++++++
 tb/tb_gshare_spec_predictor.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/gshare_spec_predictor_pkg.sv
// Shared types for the gshare predictor: sweep FSM states, 2-bit counter encodings
// and the saturating counter update.
package gshare_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_spec_predictor_if.sv
// Fetch-side prediction and EX-side resolution signals of the gshare predictor.
// master drives fetch PC and resolved branches; slave is the predictor itself.
interface gshare_spec_predictor_if #(
  parameter int GHR_BITS = 10
);
  logic [31:0]         pc;
  logic                predict_en;
  logic [31:0]         next_pc;
  logic                predict_taken;
  logic [GHR_BITS-1:0] predict_ghr;
  logic                init_busy;
  logic                update_valid;
  logic [31:0]         update_pc;
  logic [31:0]         update_target;
  logic                update_taken;
  logic [GHR_BITS-1:0] update_ghr;
  logic                update_mispredict;

  modport master (
    output pc, predict_en,
    output update_valid, update_pc, update_target, update_taken, update_ghr, update_mispredict,
    input  next_pc, predict_taken, predict_ghr, init_busy
  );

  modport slave (
    input  pc, predict_en,
    input  update_valid, update_pc, update_target, update_taken, update_ghr, update_mispredict,
    output next_pc, predict_taken, predict_ghr, init_busy
  );
endinterface

// File: rtl/gshare_spec_predictor_btb_table.sv
// Direct-mapped BTB: combinational lookup, one write port, one valid-clear port.
// Writes land on the clock edge, so a same-cycle lookup sees the old entry.
module btb_table #(
  parameter int IDX_BITS = 5,
  parameter int TAG_BITS = 25
) (
  input  logic                clk,
  input  logic [IDX_BITS-1:0] lookup_idx,
  input  logic [TAG_BITS-1:0] lookup_tag,
  output logic                hit,
  output logic [31:0]         lookup_target,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [31:0]         wr_target,
  input  logic                clr_en,
  input  logic [IDX_BITS-1:0] clr_idx
);
  localparam int ENTRIES = 1 << IDX_BITS;

  logic                valid  [ENTRIES];
  logic [TAG_BITS-1:0] tag    [ENTRIES];
  logic [31:0]         target [ENTRIES];

  // Clearing only happens during the init sweep, writes only afterwards.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
    if (wr_en) begin
      tag[wr_idx]    <= wr_tag;
      target[wr_idx] <= wr_target;
    end
  end

  assign hit           = valid[lookup_idx] && (tag[lookup_idx] == lookup_tag);
  assign lookup_target = target[lookup_idx];

endmodule

// File: rtl/gshare_spec_predictor.sv
// gshare/bimodal direction predictor with BTB, speculative history and mispredict repair.
// Zero-latency combinational prediction; tables swept to a known state after reset.
module gshare_spec_predictor
  import gshare_pkg::*;
#(
  parameter int         GHR_BITS     = 10,
  parameter int         BTB_IDX_BITS = 5,
  parameter bit         USE_GHR      = 1'b1,
  parameter logic [1:0] CTR_INIT     = 2'b01
) (
  input logic                   clk,
  input logic                   reset,
  gshare_spec_predictor_if.slave bus
);
  localparam int          TAG_BITS = 30 - BTB_IDX_BITS;
  localparam int          PHT_SIZE = 1 << GHR_BITS;
  localparam logic [31:0] BTB_SIZE = 32'(1) << BTB_IDX_BITS;

  state_t              state, state_nxt;
  logic [GHR_BITS-1:0] init_ptr, init_ptr_nxt;
  logic [GHR_BITS-1:0] spec_ghr, spec_ghr_nxt;
  logic                ready;

  logic [1:0]          pht [PHT_SIZE];
  logic [GHR_BITS-1:0] pht_idx, upd_idx;
  logic [1:0]          pred_ctr, upd_ctr;

  logic                btb_hit;
  logic [31:0]         btb_target;
  logic                predict_taken;
  logic                upd_en, clr_en;
  logic                unused_ok;

  assign ready   = (state == READY);
  assign upd_en  = ready & bus.update_valid;
  assign clr_en  = !ready && ({{(32-GHR_BITS){1'b0}}, init_ptr} < BTB_SIZE);

  // Update side hashes with the snapshot carried down the pipe, not the live history.
  assign pht_idx  = USE_GHR ? (bus.pc[GHR_BITS+1:2] ^ spec_ghr) : bus.pc[GHR_BITS+1:2];
  assign upd_idx  = USE_GHR ? (bus.update_pc[GHR_BITS+1:2] ^ bus.update_ghr)
                            : bus.update_pc[GHR_BITS+1:2];
  assign pred_ctr = pht[pht_idx];
  assign upd_ctr  = pht[upd_idx];

  btb_table #(
    .IDX_BITS (BTB_IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_btb (
    .clk           (clk),
    .lookup_idx    (bus.pc[BTB_IDX_BITS+1:2]),
    .lookup_tag    (bus.pc[31:BTB_IDX_BITS+2]),
    .hit           (btb_hit),
    .lookup_target (btb_target),
    .wr_en         (upd_en & bus.update_taken),
    .wr_idx        (bus.update_pc[BTB_IDX_BITS+1:2]),
    .wr_tag        (bus.update_pc[31:BTB_IDX_BITS+2]),
    .wr_target     (bus.update_target),
    .clr_en        (clr_en),
    .clr_idx       (init_ptr[BTB_IDX_BITS-1:0])
  );

  assign predict_taken     = ready & btb_hit & pred_ctr[1];
  assign bus.predict_taken = predict_taken;
  assign bus.next_pc       = predict_taken ? btb_target : bus.pc + 32'd4;
  assign bus.predict_ghr   = spec_ghr;
  assign bus.init_busy     = !ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_ptr <= '0;
      spec_ghr <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
      spec_ghr <= spec_ghr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    unique case (state)
      INIT: begin
        init_ptr_nxt = init_ptr + 1'b1;
        if (init_ptr == '1) begin
          state_nxt = READY;
        end
      end
      READY: begin
        state_nxt = READY;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // Repair from the resolved branch beats any same-cycle speculative shift.
  always_comb begin
    spec_ghr_nxt = spec_ghr;
    if (upd_en && bus.update_mispredict) begin
      spec_ghr_nxt = {bus.update_ghr[GHR_BITS-2:0], bus.update_taken};
    end else if (ready && bus.predict_en && btb_hit) begin
      spec_ghr_nxt = {spec_ghr[GHR_BITS-2:0], predict_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (!ready) begin
      pht[init_ptr] <= CTR_INIT;
    end else if (upd_en) begin
      pht[upd_idx] <= sat_ctr_next(upd_ctr, bus.update_taken);
    end
  end

  assign unused_ok = ^{bus.update_pc[1:0], bus.update_ghr};

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Self-checking bench: reset/init-sweep timing, table-driven prediction/update vectors
// with a scoreboard queue, and async reset during operation and mid-sweep.
module tb_gshare_spec_predictor;
  localparam int G = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gshare_spec_predictor_if #(.GHR_BITS(G)) bus ();

  gshare_spec_predictor #(
    .GHR_BITS     (G),
    .BTB_IDX_BITS (5),
    .USE_GHR      (1'b1),
    .CTR_INIT     (2'b01)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0]  pc;
    logic         en;
    logic         uv;
    logic [31:0]  upc;
    logic [31:0]  utgt;
    logic         ut;
    logic [G-1:0] ughr;
    logic         um;
    logic         xt;
    logic [31:0]  xnpc;
    logic [G-1:0] xghr;
  } vec_t;

  typedef struct packed {
    logic         t;
    logic [31:0]  npc;
    logic [G-1:0] ghr;
  } exp_t;

  localparam int NV = 29;
  vec_t vecs[NV];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] pc, input logic en, input logic uv,
                               input logic [31:0] upc, input logic [31:0] utgt, input logic ut,
                               input logic [G-1:0] ughr, input logic um, input logic xt,
                               input logic [31:0] xnpc, input logic [G-1:0] xghr);
    vec_t v;
    v.pc = pc; v.en = en; v.uv = uv; v.upc = upc; v.utgt = utgt; v.ut = ut;
    v.ughr = ughr; v.um = um; v.xt = xt; v.xnpc = xnpc; v.xghr = xghr;
    return v;
  endfunction

  task automatic drive_idle(input logic [31:0] pc);
    bus.pc = pc;
    bus.predict_en = 1'b0;
    bus.update_valid = 1'b0;
    bus.update_pc = 32'h0;
    bus.update_target = 32'h0;
    bus.update_taken = 1'b0;
    bus.update_ghr = '0;
    bus.update_mispredict = 1'b0;
  endtask

  // Releases reset away from the edge and counts negedge samples with init_busy high.
  task automatic release_and_count(output int n, output int bad, input logic [31:0] exp_npc);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n = 0;
    bad = 0;
    while (bus.init_busy === 1'b1 && n < 2000) begin
      if (bus.predict_taken !== 1'b0 || bus.next_pc !== exp_npc) bad++;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, bad;
    exp_t e;

    // pc, en, uv, upc, utgt, ut, ughr, um | exp taken, next_pc, ghr
    vecs[0]  = mkv(32'h40, 0, 1, 32'h40, 32'h200, 1, 10'h000, 0, 0, 32'h44,  10'h000);
    vecs[1]  = mkv(32'h40, 0, 0, 32'h0,  32'h0,   0, 10'h000, 0, 1, 32'h200, 10'h000);
    vecs[2]  = mkv(32'h40, 1, 0, 32'h0,  32'h0,   0, 10'h000, 0, 1, 32'h200, 10'h000);
    vecs[3]  = mkv(32'h40, 0, 0, 32'h0,  32'h0,   0, 10'h000, 0, 0, 32'h44,  10'h001);
    vecs[4]  = mkv(32'h40, 1, 1, 32'h40, 32'h0,   0, 10'h155, 1, 0, 32'h44,  10'h001);
    vecs[5]  = mkv(32'hC0, 1, 0, 32'h0,  32'h0,   0, 10'h000, 0, 0, 32'hC4,  10'h2AA);
    vecs[6]  = mkv(32'hC0, 0, 0, 32'h0,  32'h0,   0, 10'h000, 0, 0, 32'hC4,  10'h2AA);
    vecs[7]  = mkv(32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0, 0, 10'h000, 0, 0, 32'h0, 10'h2AA);
    vecs[8]  = mkv(32'h40, 0, 1, 32'h800, 32'h0,  0, 10'h000, 1, 0, 32'h44,  10'h2AA);
    vecs[9]  = mkv(32'h40, 0, 0, 32'h0,  32'h0,   0, 10'h000, 0, 1, 32'h200, 10'h000);
    vecs[10] = mkv(32'h40, 0, 1, 32'h40, 32'h300, 1, 10'h000, 0, 1, 32'h200, 10'h000);
    vecs[11] = mkv(32'h40, 0, 1, 32'h40, 32'h300, 1, 10'h000, 0, 1, 32'h300, 10'h000);
    vecs[12] = mkv(32'h40, 0, 1, 32'h40, 32'h500, 0, 10'h000, 0, 1, 32'h300, 10'h000);
    vecs[13] = mkv(32'h40, 0, 1, 32'h40, 32'h500, 0, 10'h000, 0, 1, 32'h300, 10'h000);
    vecs[14] = mkv(32'h40, 0, 0, 32'h0,  32'h0,   0, 10'h000, 0, 0, 32'h44,  10'h000);
    vecs[15] = mkv(32'h40, 0, 1, 32'h40, 32'h500, 0, 10'h000, 0, 0, 32'h44,  10'h000);
    vecs[16] = mkv(32'h40, 0, 1, 32'h40, 32'h500, 0, 10'h000, 0, 0, 32'h44,  10'h000);
    vecs[17] = mkv(32'h40, 0, 1, 32'h40, 32'h300, 1, 10'h000, 0, 0, 32'h44,  10'h000);
    vecs[18] = mkv(32'h40, 0, 1, 32'h40, 32'h300, 1, 10'h000, 0, 0, 32'h44,  10'h000);
    vecs[19] = mkv(32'h40, 1, 0, 32'h0,  32'h0,   0, 10'h000, 0, 1, 32'h300, 10'h000);
    vecs[20] = mkv(32'h40, 0, 0, 32'h0,  32'h0,   0, 10'h000, 0, 0, 32'h44,  10'h001);
    vecs[21] = mkv(32'h40, 1, 0, 32'h0,  32'h0,   0, 10'h000, 0, 0, 32'h44,  10'h001);
    vecs[22] = mkv(32'h40, 0, 0, 32'h0,  32'h0,   0, 10'h000, 0, 0, 32'h44,  10'h002);
    vecs[23] = mkv(32'h40, 0, 1, 32'h800, 32'h0,  0, 10'h000, 1, 0, 32'h44,  10'h002);
    vecs[24] = mkv(32'h40, 0, 0, 32'h0,  32'h0,   0, 10'h000, 0, 1, 32'h300, 10'h000);
    vecs[25] = mkv(32'h40, 0, 1, 32'h44, 32'h600, 1, 10'h001, 0, 1, 32'h300, 10'h000);
    vecs[26] = mkv(32'h40, 0, 1, 32'h44, 32'h600, 1, 10'h001, 0, 1, 32'h300, 10'h000);
    vecs[27] = mkv(32'h40, 1, 0, 32'h0,  32'h0,   0, 10'h000, 0, 1, 32'h300, 10'h000);
    vecs[28] = mkv(32'h44, 0, 0, 32'h0,  32'h0,   0, 10'h000, 0, 1, 32'h600, 10'h001);

    // Reset held with hostile traffic that the sweep must ignore.
    drive_idle(32'h100);
    bus.predict_en = 1'b1;
    bus.update_valid = 1'b1;
    bus.update_pc = 32'h40;
    bus.update_target = 32'h200;
    bus.update_taken = 1'b1;
    bus.update_ghr = 10'h155;
    bus.update_mispredict = 1'b1;
    #23;
    chk("rst_init_busy", 32'(bus.init_busy), 32'h1);
    chk("rst_taken", 32'(bus.predict_taken), 32'h0);
    chk("rst_next_pc", bus.next_pc, 32'h104);
    chk("rst_ghr", 32'(bus.predict_ghr), 32'h0);

    release_and_count(n, bad, 32'h104);
    drive_idle(32'h40);
    chk("init_cycles", 32'(n), 32'd1024);
    chk("init_forced_nt", 32'(bad), 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      bus.pc = vecs[i].pc;
      bus.predict_en = vecs[i].en;
      bus.update_valid = vecs[i].uv;
      bus.update_pc = vecs[i].upc;
      bus.update_target = vecs[i].utgt;
      bus.update_taken = vecs[i].ut;
      bus.update_ghr = vecs[i].ughr;
      bus.update_mispredict = vecs[i].um;
      sb.push_back('{t: vecs[i].xt, npc: vecs[i].xnpc, ghr: vecs[i].xghr});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_taken", i), 32'(bus.predict_taken), 32'(e.t));
      chk($sformatf("v%0d_next_pc", i), bus.next_pc, e.npc);
      chk($sformatf("v%0d_ghr", i), 32'(bus.predict_ghr), 32'(e.ghr));
      chk($sformatf("v%0d_busy", i), 32'(bus.init_busy), 32'h0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Async reset while pc=0x44 is predicted taken with non-zero history.
    drive_idle(32'h44);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.init_busy), 32'h1);
    chk("arst_taken", 32'(bus.predict_taken), 32'h0);
    chk("arst_next_pc", bus.next_pc, 32'h48);
    chk("arst_ghr", 32'(bus.predict_ghr), 32'h0);

    @(posedge clk);
    #1 reset = 1'b1;
    repeat (300) @(negedge clk);
    chk("mid_sweep_busy", 32'(bus.init_busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.init_busy), 32'h1);
    chk("mid_rst_next_pc", bus.next_pc, 32'h48);

    drive_idle(32'h40);
    release_and_count(n, bad, 32'h44);
    chk("reinit_cycles", 32'(n), 32'd1024);
    chk("reinit_forced_nt", 32'(bad), 32'd0);
    chk("post_taken_40", 32'(bus.predict_taken), 32'h0);
    chk("post_next_pc_40", bus.next_pc, 32'h44);
    bus.pc = 32'h44;
    #1;
    chk("post_taken_44", 32'(bus.predict_taken), 32'h0);
    chk("post_next_pc_44", bus.next_pc, 32'h48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
